player_motion_ctrl: RTL and testbench

- Consumer side of the player/border collision interface: turns debounced direction buttons into the registered player_x/player_y that the border-collision check and the renderer read.
- Updates once per frame_tick. Applies hold-to-accelerate speed, then clamps the player circle inside the current battle-box border.
- Reports which border edges stopped motion this frame.
- Sits between input debouncing and the battle-box collision/render path.

---
 rtl/player_motion_ctrl.sv | 145 ++++++++++++++
 tb/tb_player_motion_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Per-frame player movement: debounced buttons in, hold-to-accelerate speed,
// then the player circle is clamped inside the current battle-box border.
module player_motion_ctrl #(
    parameter int R            = 8,
    parameter int RESET_X      = 320,
    parameter int RESET_Y      = 360,
    parameter int SPEED_MIN    = 1,
    parameter int SPEED_MAX    = 2,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       recenter,
    input  logic [9:0] border_x1,
    input  logic [9:0] border_x2,
    input  logic [9:0] border_y1,
    input  logic [9:0] border_y2,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       moving,
    output logic [1:0] blocked_x,
    output logic [1:0] blocked_y
);

    localparam int CW = $clog2(ACCEL_FRAMES + 1);
    localparam logic signed [11:0] R_S       = 12'(R);
    localparam logic signed [11:0] SPD_MIN_S = 12'(SPEED_MIN);
    localparam logic signed [11:0] SPD_MAX_S = 12'(SPEED_MAX);

    typedef enum logic {IDLE, MOVE} state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic [1:0] blk;
    } axis_t;

    function automatic logic [9:0] midpoint(input logic [9:0] a1, input logic [9:0] a2);
        logic [10:0] sum;
        sum = {1'b0, a1} + {1'b0, a2};
        return 10'(sum >> 1);
    endfunction

    // Signed 12-bit candidate so stepping past 0 or 1023 compares correctly
    // against the clamp limits; blk bit1 = high side clamped, bit0 = low side.
    function automatic axis_t step_axis(
        input logic [9:0]         cur,
        input logic               inc,
        input logic               dec,
        input logic signed [11:0] spd,
        input logic [9:0]         a1,
        input logic [9:0]         a2
    );
        logic signed [11:0] cand;
        logic signed [11:0] lo;
        logic signed [11:0] hi;
        axis_t              res;
        cand = $signed({2'b00, cur});
        if (inc && !dec) begin
            cand = cand + spd;
        end else if (dec && !inc) begin
            cand = cand - spd;
        end
        lo = $signed({2'b00, a1}) + R_S;
        hi = $signed({2'b00, a2}) - R_S;
        if (hi < lo) begin
            res.pos = midpoint(a1, a2);
            res.blk = 2'b11;
        end else if (cand < lo) begin
            res.pos = 10'(lo);
            res.blk = 2'b01;
        end else if (cand > hi) begin
            res.pos = 10'(hi);
            res.blk = 2'b10;
        end else begin
            res.pos = 10'(cand);
            res.blk = 2'b00;
        end
        return res;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_hold;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic            r_moving;
    logic [1:0]      r_blk_x;
    logic [1:0]      r_blk_y;

    logic               w_net;
    logic signed [11:0] w_speed;
    logic [CW-1:0]      w_hold_next;
    axis_t              w_ax;
    axis_t              w_ay;

    assign w_net       = (btn_right ^ btn_left) | (btn_down ^ btn_up);
    assign w_speed     = (r_state == MOVE && r_hold >= CW'(ACCEL_FRAMES)) ? SPD_MAX_S : SPD_MIN_S;
    assign w_hold_next = (r_state == IDLE) ? CW'(1) :
                         (r_hold >= CW'(ACCEL_FRAMES)) ? CW'(ACCEL_FRAMES) : r_hold + 1'b1;
    assign w_ax        = step_axis(r_x, btn_right, btn_left, w_speed, border_x1, border_x2);
    assign w_ay        = step_axis(r_y, btn_down, btn_up, w_speed, border_y1, border_y2);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_x      <= 10'(RESET_X);
            r_y      <= 10'(RESET_Y);
            r_moving <= 1'b0;
            r_blk_x  <= 2'b00;
            r_blk_y  <= 2'b00;
        end else if (frame_tick) begin
            if (recenter) begin
                r_state  <= IDLE;
                r_hold   <= '0;
                r_x      <= midpoint(border_x1, border_x2);
                r_y      <= midpoint(border_y1, border_y2);
                r_moving <= 1'b0;
                r_blk_x  <= 2'b00;
                r_blk_y  <= 2'b00;
            end else begin
                r_state  <= w_net ? MOVE : IDLE;
                r_hold   <= w_net ? w_hold_next : '0;
                r_x      <= w_ax.pos;
                r_y      <= w_ay.pos;
                r_moving <= w_net;
                r_blk_x  <= w_ax.blk;
                r_blk_y  <= w_ay.blk;
            end
        end
    end

    assign player_x  = r_x;
    assign player_y  = r_y;
    assign moving    = r_moving;
    assign blocked_x = r_blk_x;
    assign blocked_y = r_blk_y;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus randomized ticks,
// all checked against an integer-arithmetic model of the player motion rules.
module tb_player_motion_ctrl;

    localparam int R     = 8;
    localparam int ACCEL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       recenter = 1'b0;
    logic [9:0] border_x1 = 10'd200, border_x2 = 10'd440;
    logic [9:0] border_y1 = 10'd250, border_y2 = 10'd390;
    logic [9:0] player_x, player_y;
    logic       moving;
    logic [1:0] blocked_x, blocked_y;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int mx, my, mhold, mbx, mby;
    bit mmov;

    player_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .recenter(recenter),
        .border_x1(border_x1), .border_x2(border_x2),
        .border_y1(border_y1), .border_y2(border_y2),
        .player_x(player_x), .player_y(player_y), .moving(moving),
        .blocked_x(blocked_x), .blocked_y(blocked_y)
    );

    always #5 clk = ~clk;

    wire [24:0] dut_vec = {player_x, player_y, moving, blocked_x, blocked_y};

    function automatic logic [24:0] exp_vec();
        return {10'(mx), 10'(my), mmov, 2'(mbx), 2'(mby)};
    endfunction

    function automatic string show();
        return $sformatf("got x=%0d y=%0d mv=%0b bx=%b by=%b, expected x=%0d y=%0d mv=%0b bx=%0d by=%0d",
                         player_x, player_y, moving, blocked_x, blocked_y, mx, my, mmov, mbx, mby);
    endfunction

    task automatic model_reset();
        mx = 320; my = 360; mhold = 0; mbx = 0; mby = 0; mmov = 0;
    endtask

    task automatic clamp_ax(input int cur, input int dir, input int spd, input int a1, input int a2,
                            output int pos, output int blk);
        int cand, lo, hi;
        cand = cur + dir * spd;
        lo   = a1 + R;
        hi   = a2 - R;
        if (hi < lo) begin
            pos = (a1 + a2) / 2; blk = 3;
        end else if (cand < lo) begin
            pos = lo; blk = 1;
        end else if (cand > hi) begin
            pos = hi; blk = 2;
        end else begin
            pos = cand; blk = 0;
        end
    endtask

    task automatic model_step();
        int dx, dy, spd;
        if (recenter) begin
            mx = (int'(border_x1) + int'(border_x2)) / 2;
            my = (int'(border_y1) + int'(border_y2)) / 2;
            mbx = 0; mby = 0; mhold = 0; mmov = 0;
        end else begin
            dx  = int'(btn_right) - int'(btn_left);
            dy  = int'(btn_down) - int'(btn_up);
            spd = (mhold >= ACCEL) ? 2 : 1;
            clamp_ax(mx, dx, spd, int'(border_x1), int'(border_x2), mx, mbx);
            clamp_ax(my, dy, spd, int'(border_y1), int'(border_y2), my, mby);
            mmov  = (dx != 0) || (dy != 0);
            mhold = mmov ? ((mhold + 1 > ACCEL) ? ACCEL : mhold + 1) : 0;
        end
    endtask

    // Inputs are set at a falling edge; the tick spans the next rising edge.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_step();
    endtask

    task automatic set_btns(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    endtask

    task automatic walk_to(input bit is_x, input int target);
        for (int n = 0; n < 800; n++) begin
            int cur, gap, spd;
            cur = is_x ? mx : my;
            gap = target - cur;
            spd = (mhold >= ACCEL) ? 2 : 1;
            if (gap == 0) break;
            if ((gap < 0 ? -gap : gap) < spd) set_btns(0, 0, 0, 0);
            else if (is_x) set_btns(0, 0, gap < 0, gap > 0);
            else set_btns(gap < 0, gap > 0, 0, 0);
            tick();
        end
        set_btns(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_vec !== {10'd320, 10'd360, 1'b0, 2'b00, 2'b00}) begin
            n_err++; $display("FAIL reset_values: %s", show());
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL reset_release_hold: %s", show());
        end
    endtask

    task automatic test_accel();
        int exp_x[6] = '{321, 322, 323, 324, 326, 328};
        set_btns(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (player_x !== 10'(exp_x[i]) || moving !== 1'b1 || dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL accel_tick%0d: %s (plan x=%0d)", i, show(), exp_x[i]);
            end
        end
        set_btns(0, 0, 0, 0);
        tick();
        n_cmp++;
        if (player_x !== 10'd328 || moving !== 1'b0 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL accel_release: %s", show());
        end
        set_btns(0, 0, 0, 1);
        tick();
        n_cmp++;
        if (player_x !== 10'd329 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL accel_counter_cleared: %s", show());
        end
        set_btns(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_right_clamp();
        walk_to(1'b1, 430);
        n_cmp++;
        if (player_x !== 10'd430 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL clamp_setup: %s", show());
        end
        set_btns(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL clamp_right_tick%0d: %s", i, show());
            end
        end
        n_cmp++;
        if (player_x !== 10'd432 || blocked_x !== 2'b10) begin
            n_err++; $display("FAIL clamp_right_edge: %s", show());
        end
        set_btns(0, 0, 0, 0);
        tick();
        n_cmp++;
        if (player_x !== 10'd432 || blocked_x !== 2'b00 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL clamp_release: %s", show());
        end
    endtask

    task automatic test_cancel();
        walk_to(1'b0, 300);
        tick();
        set_btns(1, 0, 1, 1);
        tick();
        n_cmp++;
        if (player_x !== 10'd432 || player_y !== 10'd299 || moving !== 1'b1 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL cancel_lr_up: %s", show());
        end
        set_btns(0, 0, 1, 1);
        tick();
        n_cmp++;
        if (player_x !== 10'd432 || player_y !== 10'd299 || moving !== 1'b0 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL cancel_lr_only: %s", show());
        end
        set_btns(0, 0, 0, 0);
    endtask

    task automatic test_border_shrink();
        walk_to(1'b0, 360);
        tick();
        border_y2 = 10'd300;
        tick();
        n_cmp++;
        if (player_y !== 10'd292 || blocked_y !== 2'b10 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL shrink_bottom: %s", show());
        end
        border_x1 = 10'd310;
        border_x2 = 10'd320;
        tick();
        n_cmp++;
        if (player_x !== 10'd315 || blocked_x !== 2'b11 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL degenerate_x: %s", show());
        end
    endtask

    task automatic test_recenter();
        border_x1 = 10'd200; border_x2 = 10'd440;
        border_y1 = 10'd250; border_y2 = 10'd390;
        recenter = 1'b1;
        set_btns(0, 0, 0, 1);
        tick();
        n_cmp++;
        if (dut_vec !== {10'd320, 10'd320, 1'b0, 2'b00, 2'b00} || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL recenter: %s", show());
        end
        recenter = 1'b0;
        tick();
        n_cmp++;
        if (player_x !== 10'd321 || dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL recenter_speed_restart: %s", show());
        end
        set_btns(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int idle;
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++) begin
                set_btns($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
                recenter = $urandom_range(0, 1);
                @(negedge clk);
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_err++; $display("FAIL random_no_tick_hold %0d: %s", i, show());
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                border_x1 = 10'($urandom_range(100, 500));
                border_x2 = border_x1 + 10'($urandom_range(0, 300));
                border_y1 = 10'($urandom_range(100, 500));
                border_y2 = border_y1 + 10'($urandom_range(0, 300));
            end
            set_btns($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            recenter = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL random_tick %0d: %s", i, show());
            end
        end
        recenter = 1'b0;
        set_btns(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        border_x1 = 10'd200; border_x2 = 10'd440;
        border_y1 = 10'd250; border_y2 = 10'd390;
        set_btns(0, 0, 1, 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== {10'd320, 10'd360, 1'b0, 2'b00, 2'b00}) begin
            n_err++; $display("FAIL async_reset_immediate: %s", show());
        end
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        frame_tick = 1'b0;
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL reset_overrides_tick: %s", show());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL post_reset_stable: %s", show());
        end
        set_btns(0, 0, 0, 0);
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL post_reset_first_tick: %s", show());
        end
    endtask

    initial begin
        test_reset();
        test_accel();
        test_right_clamp();
        test_cancel();
        test_border_shrink();
        test_recenter();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
